// File: rtl/ecc_ctrl_pkg.sv
// Shared definitions for the ECC APB controller: register map,
// operand enums, sequencer states and STATUS bit positions.
package ecc_ctrl_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_DATA   = 3'd1;
    localparam logic [2:0] OFF_WIDTH  = 3'd2;
    localparam logic [2:0] OFF_NOISE  = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    typedef enum logic [1:0] {
        MODE_ENC  = 2'd0,
        MODE_DEC  = 2'd1,
        MODE_FULL = 2'd2,
        MODE_ILL  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        WIDTH_8   = 2'd0,
        WIDTH_16  = 2'd1,
        WIDTH_32  = 2'd2,
        WIDTH_RSV = 2'd3
    } width_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_REJECT  = 2;
    localparam int STAT_NERR    = 3;

endpackage

// File: rtl/ecc_apb_regfile.sv
// APB decode, configuration storage, read mux and STATUS sticky bits.
// Emits a one-cycle launch request or reject for each CTRL write.
module ecc_apb_regfile
    import ecc_ctrl_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    input  logic [AMBA_WORD-1:0]       pwdata,
    output logic [AMBA_WORD-1:0]       prdata,
    input  logic                       i_busy,
    input  logic                       i_timeout,
    input  logic [1:0]                 i_last_nerr,
    output logic                       o_launch_req,
    output logic                       o_reject,
    output logic [1:0]                 o_mode,
    output logic [1:0]                 o_width,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic [DATA_WIDTH-1:0]      o_noise
);

    logic [2:0]            w_addr;
    logic                  w_wr;
    logic                  w_ctrl_wr;
    logic                  w_illegal;
    logic                  w_stat_rd;
    logic                  w_unused;
    mode_t                 r_mode;
    width_t                r_width;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_noise;
    logic                  r_timeout;
    logic                  r_reject;

    assign w_addr    = paddr[4:2];
    assign w_unused  = ^{paddr[AMBA_ADDR_WIDTH-1:5], paddr[1:0]};
    assign w_wr      = psel & penable & pwrite;
    assign w_ctrl_wr = w_wr && (w_addr == OFF_CTRL);
    assign w_illegal = (pwdata[1:0] == MODE_ILL);
    assign w_stat_rd = psel & penable & ~pwrite
                     & (w_addr == OFF_STATUS);

    assign o_launch_req = w_ctrl_wr & ~i_busy & ~w_illegal;
    assign o_reject     = w_ctrl_wr & (i_busy | w_illegal);

    assign o_mode  = r_mode;
    assign o_width = r_width;
    assign o_data  = r_data;
    assign o_noise = r_noise;

    // Mode only changes on an accepted launch so a rejected write
    // cannot disturb an operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= MODE_ENC;
            r_width   <= WIDTH_8;
            r_data    <= '0;
            r_noise   <= '0;
            r_timeout <= 1'b0;
            r_reject  <= 1'b0;
        end else begin
            if (o_launch_req)
                r_mode <= mode_t'(pwdata[1:0]);
            if (w_wr && (w_addr == OFF_DATA))
                r_data <= pwdata[DATA_WIDTH-1:0];
            if (w_wr && (w_addr == OFF_WIDTH))
                r_width <= width_t'(pwdata[1:0]);
            if (w_wr && (w_addr == OFF_NOISE))
                r_noise <= pwdata[DATA_WIDTH-1:0];
            r_timeout <= i_timeout | (r_timeout & ~w_stat_rd);
            r_reject  <= o_reject | (r_reject & ~w_stat_rd);
        end
    end

    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            case (w_addr)
                OFF_CTRL:   prdata[1:0] = r_mode;
                OFF_DATA:   prdata[DATA_WIDTH-1:0] = r_data;
                OFF_WIDTH:  prdata[1:0] = r_width;
                OFF_NOISE:  prdata[DATA_WIDTH-1:0] = r_noise;
                OFF_STATUS: begin
                    prdata[STAT_BUSY]      = i_busy;
                    prdata[STAT_TIMEOUT]   = r_timeout;
                    prdata[STAT_REJECT]    = r_reject;
                    prdata[STAT_NERR +: 2] = i_last_nerr;
                end
                default:    prdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/ecc_apb_ctrl.sv
// ECC core sequencer: launches one operation per accepted CTRL write,
// waits for completion or timeout, and captures the result.
module ecc_apb_ctrl
    import ecc_ctrl_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    input  logic [AMBA_WORD-1:0]       pwdata,
    output logic [AMBA_WORD-1:0]       prdata,
    output logic                       core_start,
    output logic [1:0]                 core_mode,
    output logic [1:0]                 core_width,
    output logic [DATA_WIDTH-1:0]      core_data,
    output logic [DATA_WIDTH-1:0]      core_noise,
    input  logic                       core_done,
    input  logic [DATA_WIDTH-1:0]      core_result,
    input  logic [1:0]                 core_nerr,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       operation_done,
    output logic [1:0]                 num_of_errors
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          w_busy;
    logic          w_launch;
    logic          w_reject_unused;
    logic          w_cnt_last;
    logic          w_capture;
    logic          w_timeout;

    ecc_apb_regfile #(
        .AMBA_WORD      (AMBA_WORD),
        .AMBA_ADDR_WIDTH(AMBA_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .i_busy      (w_busy),
        .i_timeout   (w_timeout),
        .i_last_nerr (num_of_errors),
        .o_launch_req(w_launch),
        .o_reject    (w_reject_unused),
        .o_mode      (core_mode),
        .o_width     (core_width),
        .o_data      (core_data),
        .o_noise     (core_noise)
    );

    // WAIT lasts at most TIMEOUT_CYCLES cycles (counter 0..N-1).
    assign w_cnt_last = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_capture  = (r_state == WAIT) & core_done;
    assign w_timeout  = (r_state == WAIT) & ~core_done & w_cnt_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_launch) w_next = LAUNCH;
            LAUNCH:  w_next = WAIT;
            WAIT:    if (core_done || w_cnt_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        core_start     = (r_state == LAUNCH);
        operation_done = (r_state == DONE);
        w_busy         = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (r_state == LAUNCH)
            r_cnt <= '0;
        else if (r_state == WAIT && r_cnt != CW'(TIMEOUT_CYCLES))
            r_cnt <= r_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out      <= '0;
            num_of_errors <= 2'd0;
        end else if (w_capture) begin
            data_out      <= core_result;
            num_of_errors <= core_nerr;
        end else if (w_timeout) begin
            num_of_errors <= 2'd2;
        end
    end

endmodule

// File: tb/tb_ecc_apb_ctrl.sv
// Directed bench for ecc_apb_ctrl with a simple delayed-response core
// model; expected values are hand-computed per scenario.
module tb_ecc_apb_ctrl;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [19:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        core_start;
    logic [1:0]  core_mode;
    logic [1:0]  core_width;
    logic [31:0] core_data;
    logic [31:0] core_noise;
    logic        core_done;
    logic [31:0] core_result;
    logic [1:0]  core_nerr;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;

    int n_tests;
    int n_fail;
    int n_start;
    int n_done;
    int cyc;
    int start_cyc;
    int done_cyc;
    int bs;
    int bd;

    logic        md_en;
    int          md_delay;
    logic [31:0] md_result;
    logic [1:0]  md_nerr;
    logic [31:0] rd;

    ecc_apb_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .psel          (psel),
        .penable       (penable),
        .pwrite        (pwrite),
        .paddr         (paddr),
        .pwdata        (pwdata),
        .prdata        (prdata),
        .core_start    (core_start),
        .core_mode     (core_mode),
        .core_width    (core_width),
        .core_data     (core_data),
        .core_noise    (core_noise),
        .core_done     (core_done),
        .core_result   (core_result),
        .core_nerr     (core_nerr),
        .data_out      (data_out),
        .operation_done(operation_done),
        .num_of_errors (num_of_errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (core_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (operation_done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // Core model: answers md_delay cycles after seeing core_start.
    initial begin
        core_done   = 1'b0;
        core_result = '0;
        core_nerr   = 2'd0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (core_start && md_en) begin
                repeat (md_delay) @(negedge clk);
                core_done   = 1'b1;
                core_result = md_result;
                core_nerr   = md_nerr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input logic [2:0] off, input logic [31:0] d);
        psel    = 1'b1;
        pwrite  = 1'b1;
        penable = 1'b0;
        paddr   = {15'd0, off, 2'b00};
        pwdata  = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_rd(input logic [2:0] off, output logic [31:0] d);
        psel    = 1'b1;
        pwrite  = 1'b0;
        penable = 1'b0;
        paddr   = {15'd0, off, 2'b00};
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata;
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic wait_done(input int base, input int bound);
        int k;
        k = 0;
        while (n_done == base && k < bound) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("wait_done", n_done, base + 1);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        n_start  = 0;
        n_done   = 0;
        cyc      = 0;
        md_en    = 1'b1;
        md_delay = 2;
        md_result = '0;
        md_nerr  = 2'd0;
        rst      = 1'b1;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_nerr", {30'd0, num_of_errors}, 32'h0);
        check("rst_opdone", {31'd0, operation_done}, 32'h0);
        check("rst_start", {31'd0, core_start}, 32'h0);
        check("rst_cfg", {core_mode, core_width}, 32'h0);
        check("rst_core_data", core_data, 32'h0);
        check("rst_core_noise", core_noise, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            apb_rd(3'(i), rd);
            check($sformatf("rst_rd%0d", i), rd, 32'h0);
        end

        // Encode, result two cycles after core_start
        apb_wr(3'd1, 32'h0000_00A5);
        apb_wr(3'd2, 32'h0);
        check("enc_core_data", core_data, 32'h0000_00A5);
        md_delay  = 2;
        md_result = 32'h0000_0C5A;
        md_nerr   = 2'd0;
        bs = n_start;
        bd = n_done;
        apb_wr(3'd0, 32'h0);
        wait_done(bd, 20);
        repeat (3) @(negedge clk);
        #1;
        check("enc_starts", n_start, bs + 1);
        check("enc_dones", n_done, bd + 1);
        check("enc_latency", done_cyc - start_cyc, 3);
        check("enc_data_out", data_out, 32'h0000_0C5A);
        check("enc_nerr", {30'd0, num_of_errors}, 32'h0);
        apb_rd(3'd4, rd);
        check("enc_status", rd, 32'h0);

        // Decode with a CTRL write during WAIT
        md_delay  = 8;
        md_result = 32'h1234_5678;
        md_nerr   = 2'd1;
        bs = n_start;
        bd = n_done;
        apb_wr(3'd0, 32'h1);
        check("dec_mode", {30'd0, core_mode}, 32'h1);
        apb_wr(3'd0, 32'h1);
        wait_done(bd, 30);
        repeat (3) @(negedge clk);
        #1;
        check("dec_starts", n_start, bs + 1);
        check("dec_data_out", data_out, 32'h1234_5678);
        check("dec_nerr", {30'd0, num_of_errors}, 32'h1);
        apb_rd(3'd4, rd);
        check("dec_status", rd, 32'h0000_000C);
        apb_rd(3'd4, rd);
        check("dec_status_clr", rd, 32'h0000_0008);
        apb_rd(3'd0, rd);
        check("dec_ctrl_rd", rd, 32'h1);

        // Minimum turnaround; CTRL write in DONE rejected, then accepted
        apb_wr(3'd3, 32'h0000_0010);
        apb_wr(3'd2, 32'h2);
        check("full_noise", core_noise, 32'h0000_0010);
        check("full_width", {30'd0, core_width}, 32'h2);
        apb_rd(3'd2, rd);
        check("full_width_rd", rd, 32'h2);
        md_delay  = 1;
        md_result = 32'hDEAD_BEEF;
        md_nerr   = 2'd0;
        bs = n_start;
        bd = n_done;
        apb_wr(3'd0, 32'h2);
        @(negedge clk);
        apb_wr(3'd0, 32'h2);
        #1;
        check("min_dones", n_done, bd + 1);
        check("min_latency", done_cyc - start_cyc, 2);
        check("min_data_out", data_out, 32'hDEAD_BEEF);
        check("done_wr_starts", n_start, bs + 1);
        md_result = 32'h0000_5555;
        apb_wr(3'd0, 32'h0);
        wait_done(bd + 1, 20);
        repeat (3) @(negedge clk);
        #1;
        check("idle_wr_starts", n_start, bs + 2);
        check("idle_wr_data", data_out, 32'h0000_5555);
        apb_rd(3'd4, rd);
        check("done_wr_status", rd, 32'h0000_0004);
        apb_rd(3'd4, rd);
        check("done_wr_clr", rd, 32'h0);

        // Illegal mode 3
        bs = n_start;
        apb_wr(3'd0, 32'h3);
        repeat (3) @(negedge clk);
        #1;
        check("ill_starts", n_start, bs);
        apb_rd(3'd4, rd);
        check("ill_status", rd, 32'h0000_0004);

        // Timeout: core never answers
        md_en = 1'b0;
        bs = n_start;
        bd = n_done;
        apb_wr(3'd0, 32'h0);
        apb_rd(3'd4, rd);
        check("to_busy", rd, 32'h0000_0001);
        wait_done(bd, 100);
        repeat (3) @(negedge clk);
        #1;
        check("to_starts", n_start, bs + 1);
        check("to_latency", done_cyc - start_cyc, 65);
        check("to_nerr", {30'd0, num_of_errors}, 32'h2);
        check("to_data_out", data_out, 32'h0000_5555);
        apb_rd(3'd4, rd);
        check("to_status", rd, 32'h0000_0012);

        // Reset during WAIT
        md_en     = 1'b1;
        md_delay  = 10;
        md_result = 32'h0000_AAAA;
        md_nerr   = 2'd3;
        apb_wr(3'd0, 32'h1);
        repeat (2) @(negedge clk);
        bd = n_done;
        #2 rst = 1'b1;
        #1;
        check("mrst_data_out", data_out, 32'h0);
        check("mrst_nerr", {30'd0, num_of_errors}, 32'h0);
        check("mrst_ctl", {30'd0, core_start, operation_done}, 32'h0);
        check("mrst_mode", {30'd0, core_mode}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("mrst_no_done", n_done, bd);
        check("mrst_data_hold", data_out, 32'h0);
        apb_rd(3'd4, rd);
        check("mrst_status", rd, 32'h0);
        md_delay  = 2;
        md_result = 32'h0000_0F0F;
        md_nerr   = 2'd1;
        bd = n_done;
        apb_wr(3'd0, 32'h2);
        wait_done(bd, 20);
        repeat (2) @(negedge clk);
        #1;
        check("post_data_out", data_out, 32'h0000_0F0F);
        check("post_nerr", {30'd0, num_of_errors}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
